// File: rtl/ldpc_row_xor_scheduler.sv
// Walks one QC-LDPC base-matrix row through a shared rotator and XOR-accumulates the rotated blocks.
// Optional shift range checking is enabled by defining LDPC_SHIFT_CHECK_EN.
module ldpc_row_xor_scheduler #(
  parameter  int MAX_BLOCK_SIZE = 64,
  parameter  int MAX_COLS       = 24,
  localparam int SHIFT_W        = $clog2(MAX_BLOCK_SIZE),
  localparam int COL_W          = $clog2(MAX_COLS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SHIFT_W-1:0]        z_size,
  input  logic [COL_W-1:0]          num_cols,
  output logic                      busy,
  output logic [COL_W-1:0]          col_idx,
  input  logic [SHIFT_W-1:0]        shift_value,
  input  logic [MAX_BLOCK_SIZE-1:0] blk_data,
  output logic [MAX_BLOCK_SIZE-1:0] rot_in,
  output logic [SHIFT_W-1:0]        rot_shift,
  output logic [SHIFT_W-1:0]        rot_width,
  input  logic [MAX_BLOCK_SIZE-1:0] rot_out,
  output logic [MAX_BLOCK_SIZE-1:0] row_out,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      err,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [COL_W-1:0]          num_q, num_d;
  logic [SHIFT_W-1:0]        z_q, z_d;
  logic [MAX_BLOCK_SIZE-1:0] acc_q, acc_d;
  logic                      err_q, err_d;
  logic                      shift_bad;

`ifdef LDPC_SHIFT_CHECK_EN
  // A null block (all-ones) is legal even though it exceeds any Z.
  assign shift_bad = (state_q == RUN) && (shift_value != '1) && (shift_value >= z_q);
`else
  assign shift_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    num_d   = num_q;
    z_d     = z_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          z_d   = z_size;
          num_d = (num_cols > COL_W'(MAX_COLS)) ? COL_W'(MAX_COLS) : num_cols;
          acc_d = '0;
          col_d = '0;
          err_d = 1'b0;
          state_d = (num_cols != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (shift_bad) begin
          err_d = 1'b1;
        end else begin
          acc_d = acc_q ^ rot_out;
        end
        col_d = col_q + COL_W'(1);
        if (col_q == num_q - COL_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (row_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      num_q   <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      num_q   <= num_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Output handshake: row_out is offered while row_valid=1 and held stable until a
  // cycle with row_valid=1 and row_ready=1; that edge completes the transfer.
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign row_valid = (state_q == DONE);
  assign row_out   = acc_q;
  assign col_idx   = (state_q == IDLE) ? '0 : col_q;
  // Outside RUN the rotator sees a null shift and no data, so rot_out is 0.
  assign rot_in    = (state_q == RUN) ? blk_data : '0;
  assign rot_shift = (state_q == RUN) ? shift_value : '1;
  assign rot_width = z_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ldpc_row_xor_scheduler.sv
// Directed bench for ldpc_row_xor_scheduler with a behavioural MSB-aligned rotator and block table.
module tb_ldpc_row_xor_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  z_size = '0;
  logic [4:0]  num_cols = '0;
  logic        busy;
  logic [4:0]  col_idx;
  logic [5:0]  shift_value;
  logic [63:0] blk_data;
  logic [63:0] rot_in;
  logic [5:0]  rot_shift;
  logic [5:0]  rot_width;
  logic [63:0] rot_out;
  logic [63:0] row_out;
  logic        row_valid;
  logic        row_ready = 1'b0;
  logic        err;
  logic [1:0]  dbg_state;

  logic [5:0]  tb_shift [32];
  logic [63:0] tb_blk [32];

  int errors = 0;
  int checks = 0;

  ldpc_row_xor_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z_size(z_size), .num_cols(num_cols),
    .busy(busy), .col_idx(col_idx), .shift_value(shift_value), .blk_data(blk_data),
    .rot_in(rot_in), .rot_shift(rot_shift), .rot_width(rot_width), .rot_out(rot_out),
    .row_out(row_out), .row_valid(row_valid), .row_ready(row_ready), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Rotate the top w bits left by sh (mod w); the all-ones shift is the null block.
  function automatic logic [63:0] rot_model(input logic [63:0] v, input logic [5:0] sh,
                                            input logic [5:0] w);
    logic [63:0] field, mask, r;
    int s;
    if (sh == 6'h3F || w == 6'd0) return 64'd0;
    mask  = (64'd1 << w) - 64'd1;
    field = v >> (64 - int'(w));
    s     = int'(sh) % int'(w);
    r     = ((field << s) | (field >> (int'(w) - s))) & mask;
    return r << (64 - int'(w));
  endfunction

  always_comb begin
    shift_value = tb_shift[col_idx];
    blk_data    = tb_blk[col_idx];
    rot_out     = rot_model(rot_in, rot_shift, rot_width);
  end

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      tb_shift[i] = 6'h3F;
      tb_blk[i]   = 64'd0;
    end
  endtask

  // Pulse start for one edge, then scramble z/num to show they are not re-sampled.
  task automatic do_start(input logic [5:0] z, input logic [4:0] n);
    @(negedge clk);
    z_size = z; num_cols = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; z_size = 6'd3; num_cols = 5'd2;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int edges = 0;
    while (!row_valid && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges + 1 !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, edges + 1, exp_lat);
    end
  endtask

  task automatic accept(input string name);
    @(negedge clk);
    row_ready = 1'b1;
    @(posedge clk); #1;
    row_ready = 1'b0;
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: row_valid=%b busy=%b, expected 0 0", name, row_valid, busy);
    end
  endtask

  task automatic check_row(input string name, input logic [63:0] exp_row, input logic exp_err);
    checks++;
    if (row_out !== exp_row || err !== exp_err || row_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s row: row_out=%h err=%b valid=%b, expected %h %b 1",
               name, row_out, err, row_valid, exp_row, exp_err);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || row_valid !== 1'b0 || row_out !== 64'd0 || err !== 1'b0 ||
        col_idx !== 5'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b row=%h err=%b col=%0d state=%0d, expected all 0",
               busy, row_valid, row_out, err, col_idx, dbg_state);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    clear_table();
    tb_shift[0] = 6'd1; tb_blk[0] = 64'h8000_0000_0000_0000;
    do_start(6'd8, 5'd1);
    wait_valid("single", 2);
    check_row("single", 64'h0100_0000_0000_0000, 1'b0);
    accept("single");
  endtask

  task automatic test_multi();
    clear_table();
    tb_shift[0] = 6'd0;  tb_blk[0] = 64'h01 << 56;
    tb_shift[1] = 6'h3F; tb_blk[1] = 64'hFF << 56;
    tb_shift[2] = 6'd2;  tb_blk[2] = 64'h01 << 56;
    do_start(6'd8, 5'd3);
    wait_valid("multi", 4);
    check_row("multi", 64'h0500_0000_0000_0000, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2); z_size = 6'd8; num_cols = 5'd1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (row_out !== 64'h0500_0000_0000_0000 || busy !== 1'b1 || row_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure cycle %0d: row=%h busy=%b valid=%b, expected 0500000000000000 1 1",
                 i, row_out, busy, row_valid);
      end
    end
    accept("backpressure");
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_zero_cols();
    clear_table();
    tb_shift[0] = 6'd0; tb_blk[0] = 64'hFF << 56;
    do_start(6'd8, 5'd0);
    wait_valid("zero_cols", 1);
    check_row("zero_cols", 64'd0, 1'b0);
    checks++;
    if (col_idx !== 5'd0) begin
      errors++;
      $display("FAIL zero_cols col_idx: got %0d, expected 0", col_idx);
    end
    accept("zero_cols");
  endtask

  task automatic test_reset_mid();
    clear_table();
    for (int i = 0; i < 5; i++) begin
      tb_shift[i] = 6'(i);
      tb_blk[i]   = (64'h01 << i) << 56;
    end
    do_start(6'd8, 5'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (col_idx !== 5'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid col: col=%0d busy=%b, expected 2 1", col_idx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || row_valid !== 1'b0 || row_out !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid async: busy=%b valid=%b row=%h, expected 0 0 0",
               busy, row_valid, row_out);
    end
    @(negedge clk); rst_n = 1'b1;
    do_start(6'd8, 5'd5);
    wait_valid("reset_mid", 6);
    check_row("reset_mid", 64'h5400_0000_0000_0000, 1'b0);
    accept("reset_mid");
  endtask

  task automatic test_clamp();
    clear_table();
    do_start(6'd8, 5'd31);
    wait_valid("clamp", 25);
    check_row("clamp", 64'd0, 1'b0);
    accept("clamp");
  endtask

  task automatic test_shift_check();
    clear_table();
    tb_shift[0] = 6'd9; tb_blk[0] = 64'hFF << 56;
    tb_shift[1] = 6'd0; tb_blk[1] = 64'h01 << 56;
    do_start(6'd8, 5'd2);
    wait_valid("shift_check", 3);
`ifdef LDPC_SHIFT_CHECK_EN
    check_row("shift_check", 64'h0100_0000_0000_0000, 1'b1);
`else
    check_row("shift_check", 64'hFE00_0000_0000_0000, 1'b0);
`endif
    accept("shift_check");
  endtask

  initial begin
    clear_table();
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_zero_cols();
    test_reset_mid();
    test_clamp();
    test_shift_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
